fp_mult_pipe: RTL and testbench



---
 rtl/fp_mult_pipe.sv | 179 +++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined parametrised floating-point multiplier
// Unpack -> mantissa multiply -> normalise -> round/pack, one result per cycle.
`timescale 1ns/1ps
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FTZ   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_underflow,
  output logic                   flag_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0] ONE  = XW'(1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, inf0;
  logic c_nan, c_inv, c_inf, c_zero;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  // Subnormal operands count as zero when flushing.
  assign zero_a = (ea == '0) && ((FTZ != 0) || (fa == '0));
  assign zero_b = (eb == '0) && ((FTZ != 0) || (fb == '0));
  assign inf_a  = (&ea) && (fa == '0);
  assign inf_b  = (&eb) && (fb == '0);
  assign nan_a  = (&ea) && (fa != '0);
  assign nan_b  = (&eb) && (fb != '0);
  assign snan_a = nan_a && !fa[MAN_W-1];
  assign snan_b = nan_b && !fb[MAN_W-1];
  assign inf0   = (inf_a && zero_b) || (zero_a && inf_b);
  assign c_nan  = nan_a || nan_b || inf0;
  assign c_inv  = snan_a || snan_b || inf0;
  assign c_inf  = (inf_a || inf_b) && !c_nan;
  assign c_zero = (zero_a || zero_b) && !c_nan && !c_inf;

  logic             v1, sign1, nan1, inv1, inf1, zero1;
  logic [XW-1:0]    esum1;
  logic [MAN_W:0]   ma1, mb1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1    <= in_valid;
      sign1 <= sa ^ sb;
      esum1 <= XW'(ea) + XW'(eb) - BIAS;
      ma1   <= {1'b1, fa};
      mb1   <= {1'b1, fb};
      nan1  <= c_nan;
      inv1  <= c_inv;
      inf1  <= c_inf;
      zero1 <= c_zero;
    end
  end

  logic             v2, sign2, nan2, inv2, inf2, zero2;
  logic [XW-1:0]    esum2;
  logic [P-1:0]     prod2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2    <= v1;
      sign2 <= sign1;
      esum2 <= esum1;
      prod2 <= P'(ma1) * P'(mb1);
      nan2  <= nan1;
      inv2  <= inv1;
      inf2  <= inf1;
      zero2 <= zero1;
    end
  end

  // Bits below the leading one; the product of two [1,2) mantissas lies in [1,4).
  logic [P-2:0] nm;
  assign nm = prod2[P-1] ? prod2[P-2:0] : {prod2[P-3:0], 1'b0};

  logic             v3, sign3, nan3, inv3, inf3, zero3, g3, r3, s3;
  logic [XW-1:0]    exp3;
  logic [MAN_W-1:0] frac3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
    end else if (adv) begin
      v3    <= v2;
      sign3 <= sign2;
      exp3  <= esum2 + XW'(prod2[P-1]);
      frac3 <= nm[P-2 -: MAN_W];
      g3    <= nm[MAN_W];
      r3    <= nm[MAN_W-1];
      s3    <= |nm[MAN_W-2:0];
      nan3  <= nan2;
      inv3  <= inv2;
      inf3  <= inf2;
      zero3 <= zero2;
    end
  end

  logic             inc, ovf, unf;
  logic [MAN_W:0]   rnd;
  logic [XW-1:0]    expf;
  logic [W-1:0]     p_next;
  logic [3:0]       f_next;

  // A rounding carry leaves the fraction all-zero, so only the exponent moves.
  assign inc  = g3 & (r3 | s3 | frac3[0]);
  assign rnd  = {1'b0, frac3} + (MAN_W+1)'(inc);
  assign expf = exp3 + XW'(rnd[MAN_W]);
  assign ovf  = $signed(expf) >= $signed(EMAX);
  assign unf  = $signed(expf) <  $signed(ONE);

  always_comb begin
    p_next = '0;
    f_next = '0;
    if (nan3) begin
      p_next    = QNAN;
      f_next[3] = inv3;
    end else if (inf3) begin
      p_next = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero3) begin
      p_next = {sign3, {(W-1){1'b0}}};
    end else if (ovf) begin
      p_next = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f_next = 4'b0101;
    end else if (unf) begin
      p_next = {sign3, {(W-1){1'b0}}};
      f_next = 4'b0011;
    end else begin
      p_next    = {sign3, expf[EXP_W-1:0], rnd[MAN_W-1:0]};
      f_next[0] = g3 | r3 | s3;
    end
    if (!v3) f_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      product        <= '0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (adv) begin
      out_valid      <= v3;
      product        <= p_next;
      flag_invalid   <= f_next[3];
      flag_overflow  <= f_next[2];
      flag_underflow <= f_next[1];
      flag_inexact   <= f_next[0];
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - randomized model-checked bench for fp32 and fp16 multipliers
`timescale 1ns/1ps
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, product;
  logic        fi, fo, fu, fx;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] ha, hb, h_product;
  logic        hfi, hfo, hfu, hfx;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .flag_invalid(fi), .flag_overflow(fo), .flag_underflow(fu), .flag_inexact(fx));

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .FTZ(1)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(ha), .b(hb),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .product(h_product),
    .flag_invalid(hfi), .flag_overflow(hfo), .flag_underflow(hfu), .flag_inexact(hfx));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  // Exact integer product of the significands, then round-half-even by remainder.
  function automatic void model(input int ew, input int mw, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] p, output logic [3:0] f);
    longint emax, bias, ex, ey, be;
    logic [63:0] fmask, fxv, fyv, full, qv, rem, half, sword;
    logic nx, ny, snx, sny, ix, iy, zx, zy;
    int L, sh;
    emax  = (64'sd1 <<< ew) - 1;
    bias  = (64'sd1 <<< (ew - 1)) - 1;
    fmask = (64'd1 << mw) - 1;
    ex    = longint'((64'(x) >> mw) & 64'(emax));
    ey    = longint'((64'(y) >> mw) & 64'(emax));
    fxv   = 64'(x) & fmask;
    fyv   = 64'(y) & fmask;
    nx = (ex == emax) && (fxv != 0);
    ny = (ey == emax) && (fyv != 0);
    snx = nx && (fxv[mw-1] == 1'b0);
    sny = ny && (fyv[mw-1] == 1'b0);
    ix = (ex == emax) && (fxv == 0);
    iy = (ey == emax) && (fyv == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    sword = 64'(x[ew+mw] ^ y[ew+mw]) << (ew + mw);
    f = 4'b0000;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      p = 32'((64'(emax) << mw) | (64'd1 << (mw - 1)));
      f[3] = snx || sny || (ix && zy) || (zx && iy);
    end else if (ix || iy) begin
      p = 32'(sword | (64'(emax) << mw));
    end else if (zx || zy) begin
      p = 32'(sword);
    end else begin
      full = (fxv | (64'd1 << mw)) * (fyv | (64'd1 << mw));
      L = 0;
      for (int i = 0; i < 64; i++) if (full[i]) L = i + 1;
      sh   = L - (mw + 1);
      qv   = full >> sh;
      rem  = full & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && qv[0])) qv = qv + 1;
      if ((qv >> (mw + 1)) != 0) begin
        qv = qv >> 1;
        sh = sh + 1;
      end
      be = longint'(sh) + ex + ey - bias - longint'(mw);
      if (be >= emax) begin
        p = 32'(sword | (64'(emax) << mw));
        f = 4'b0101;
      end else if (be <= 0) begin
        p = 32'(sword);
        f = 4'b0011;
      end else begin
        p = 32'(sword | (64'(be) << mw) | (qv & fmask));
        f[0] = (rem != 0);
      end
    end
  endfunction

  task automatic pin(input int ew, input int mw, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ep, input logic [3:0] ef);
    logic [31:0] p;
    logic [3:0]  f;
    model(ew, mw, x, y, p, f);
    check($sformatf("model_%0h_x_%0h", x, y), {28'd0, f, p}, {28'd0, ef, ep});
  endtask

  function automatic logic [31:0] rnd_fp(input int ew, input int mw);
    logic [63:0] emax, e, fr;
    logic s;
    emax = (64'd1 << ew) - 1;
    s    = 1'($urandom_range(0, 1));
    fr   = {$urandom, $urandom} & ((64'd1 << mw) - 1);
    case ($urandom_range(0, 9))
      0: begin e = emax; if ($urandom_range(0, 1) == 1) fr = 0; end
      1: e = 0;
      2: e = emax - 1 - 64'($urandom_range(0, 3));
      3: e = 1 + 64'($urandom_range(0, 3));
      4: begin e = (emax >> 1) + 64'($urandom_range(0, 2)); fr = fr & 64'hF; end
      5: e = 64'($urandom_range(0, 65535)) % (emax + 1);
      default: e = (emax >> 1) - 4 + 64'($urandom_range(0, 8));
    endcase
    return 32'((64'(s) << (ew + mw)) | (e << mw) | fr);
  endfunction

  typedef struct {
    logic [31:0] p;
    logic [3:0]  f;
    int          cyc;
    int          stalls;
  } exp_t;

  exp_t        q[2][$];
  int          cyc = 0;
  int          stalls[2] = '{0, 0};
  logic        held[2] = '{1'b0, 1'b0};
  logic [31:0] hp[2];
  logic [3:0]  hf[2];
  logic        mv[2], mr[2], miv[2], mir[2];
  logic [31:0] mp[2], mxa[2], mxb[2];
  logic [3:0]  mf[2];

  always_comb begin
    mv[0] = out_valid;   mr[0] = out_ready;   miv[0] = in_valid;   mir[0] = in_ready;
    mp[0] = product;     mxa[0] = a;          mxb[0] = b;          mf[0] = {fi, fo, fu, fx};
    mv[1] = h_out_valid; mr[1] = h_out_ready; miv[1] = h_in_valid; mir[1] = h_in_ready;
    mp[1] = {16'd0, h_product}; mxa[1] = {16'd0, ha}; mxb[1] = {16'd0, hb};
    mf[1] = {hfi, hfo, hfu, hfx};
  end

  // Compare process: transfers are sampled mid-cycle and take effect at the next rising edge.
  always @(negedge clk) begin
    exp_t  e;
    string pfx;
    int    ew, mw;
    cyc++;
    if (rst) begin
      q[0].delete();
      q[1].delete();
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pfx = (k == 0) ? "f32_" : "f16_";
        ew  = (k == 0) ? 8 : 5;
        mw  = (k == 0) ? 23 : 10;
        if (held[k]) begin
          check({pfx, "hold_valid"}, 64'(mv[k]), 64'd1);
          check({pfx, "hold_product"}, 64'(mp[k]), 64'(hp[k]));
          check({pfx, "hold_flags"}, 64'(mf[k]), 64'(hf[k]));
        end
        if (mv[k] && !mr[k]) check({pfx, "in_ready_stalled"}, 64'(mir[k]), 64'd0);
        held[k] = mv[k] && !mr[k];
        hp[k]   = mp[k];
        hf[k]   = mf[k];
        if (mv[k] && mr[k]) begin
          if (q[k].size() == 0) begin
            check({pfx, "unexpected_output"}, 64'(mp[k]), 64'hDEAD_BEEF_DEAD_BEEF);
          end else begin
            e = q[k].pop_front();
            check({pfx, "product"}, 64'(mp[k]), 64'(e.p));
            check({pfx, "flags"}, 64'(mf[k]), 64'(e.f));
            check({pfx, "latency"}, 64'(cyc - e.cyc), 64'(4 + stalls[k] - e.stalls));
          end
        end
        if (miv[k] && mir[k]) begin
          model(ew, mw, mxa[k], mxb[k], e.p, e.f);
          e.cyc    = cyc;
          e.stalls = stalls[k];
          q[k].push_back(e);
        end
        if (mv[k] && !mr[k]) stalls[k]++;
      end
    end
  end

  task automatic send32(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    in_valid = 1'b1; a = x; b = y;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check("f32_send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    h_in_valid = 1'b1; ha = x; hb = y;
    @(negedge clk);
    while (!h_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!h_in_ready) check("f16_send_timeout", 64'(h_in_ready), 64'd1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q[0].size() != 0 || q[1].size() != 0); i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(q[0].size() + q[1].size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        p32, p16;
    logic [31:0] ra, rb, tmp;
    logic [15:0] rha, rhb;
    int          n32, n16;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; ha = '0; hb = '0; h_out_ready = 1'b1;

    pin(8, 23, 32'h40400000, 32'h40800000, 32'h41400000, 4'b0000);
    pin(8, 23, 32'hC0200000, 32'h40200000, 32'hC0C80000, 4'b0000);
    pin(8, 23, 32'hC1200000, 32'hC0A00000, 32'h42480000, 4'b0000);
    pin(8, 23, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    pin(8, 23, 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000);
    pin(8, 23, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    pin(8, 23, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    pin(8, 23, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
    pin(8, 23, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    pin(8, 23, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    pin(8, 23, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    pin(5, 10, 32'h4200, 32'h4400, 32'h4A00, 4'b0000);
    pin(5, 10, 32'h7BFF, 32'h4000, 32'h7C00, 4'b0101);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_flags", 64'({fi, fo, fu, fx}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_h_out_valid", 64'(h_out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send32(32'h40400000, 32'h40800000);
    send32(32'hC0200000, 32'h40200000);
    send32(32'hC1200000, 32'hC0A00000);
    send32(32'h7F800000, 32'h00000000);
    send32(32'h7F800000, 32'h40000000);
    send32(32'h7F800001, 32'h3F800000);
    send32(32'h80000000, 32'h3F800000);
    send32(32'h7F7FFFFF, 32'h7F7FFFFF);
    send32(32'h00800000, 32'h3F000000);
    send32(32'h3F800001, 32'h3F800001);
    send32(32'h3FC00000, 32'h3FC00000);
    send16(16'h4200, 16'h4400);
    send16(16'h7BFF, 16'h4000);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send32(rnd_fp(8, 23), rnd_fp(8, 23));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    @(posedge clk); #1;
    send32(32'h40400000, 32'h40800000);
    send32(32'h3FC00000, 32'h3FC00000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    p32 = 1'b0; p16 = 1'b0; n32 = 0; n16 = 0;
    ra = '0; rb = '0; rha = '0; rhb = '0;
    for (int c = 0; c < 3000 && (n32 < 400 || n16 < 300); c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      h_out_ready = ($urandom_range(0, 3) != 0);
      if (!p32 && n32 < 400 && $urandom_range(0, 4) != 0) begin
        ra = rnd_fp(8, 23); rb = rnd_fp(8, 23); p32 = 1'b1;
      end
      if (!p16 && n16 < 300 && $urandom_range(0, 4) != 0) begin
        tmp = rnd_fp(5, 10); rha = tmp[15:0];
        tmp = rnd_fp(5, 10); rhb = tmp[15:0];
        p16 = 1'b1;
      end
      in_valid = p32; a = ra; b = rb;
      h_in_valid = p16; ha = rha; hb = rhb;
      @(negedge clk);
      if (p32 && in_ready) begin p32 = 1'b0; n32++; end
      if (p16 && h_in_ready) begin p16 = 1'b0; n16++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; h_in_valid = 1'b0;
    out_ready = 1'b1; h_out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
